// File: rtl/cell_state_streamer.sv
// Writes a forward-pass cell-state stream into memory port A, then replays it
// through port B in reverse timestep order, using a 2-entry output FIFO for backprop.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start_wr / start_rd (start_wr has priority)
//  S_WRITE | accepting producer beats, writing port A
//  S_READ  | issuing port B reads, reverse timestep order
//  S_DRAIN | all reads issued, waiting for FIFO and in-flight read to empty
//  S_DONE  | one-cycle done pulse, then back to idle
module cell_state_streamer #(
    parameter int ADDR     = 12,
    parameter int WIDTH    = 32,
    parameter int NUM      = 53,
    parameter int TIMESTEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_wr,
    input  logic             start_rd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             mem_wr,
    output logic [ADDR-1:0]  mem_addr_a,
    output logic [WIDTH-1:0] mem_din,
    output logic [ADDR-1:0]  mem_addr_b,
    input  logic [WIDTH-1:0] mem_dout_b,
    output logic             busy,
    output logic             done
);
    localparam int NW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int TW = $clog2(TIMESTEP) + 1;
    localparam logic [ADDR-1:0] STEP      = ADDR'(NUM);
    localparam logic [ADDR-1:0] LAST_BASE = ADDR'((TIMESTEP - 1) * NUM);
    localparam logic [NW-1:0]   N_LAST    = NW'(NUM - 1);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMESTEP - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [NW-1:0]    n_cnt;
    logic [TW-1:0]    t_cnt;
    logic [ADDR-1:0]  base;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] fifo_mem [2];
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;
    logic             in_flight;
    logic             accept, issue, pop, n_wrap;

    always_comb begin
        in_ready   = (state == S_WRITE);
        accept     = in_ready && in_valid;
        out_valid  = (count != 2'd0);
        out_data   = fifo_mem[rd_ptr];
        pop        = out_valid && out_ready;
        // A pop in the same cycle frees a slot, which keeps one beat per cycle.
        issue      = (state == S_READ) &&
                     (({1'b0, count} + {2'b00, in_flight}) < ({2'b00, pop} + 3'd2));
        n_wrap     = (n_cnt == N_LAST);
        addr       = base + ADDR'(n_cnt);
        mem_wr     = accept;
        mem_addr_a = accept ? addr : '0;
        mem_din    = accept ? in_data : '0;
        mem_addr_b = issue ? addr : '0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_wr)      state_nxt = S_WRITE;
                else if (start_rd) state_nxt = S_READ;
            end
            S_WRITE: if (accept && n_wrap && t_cnt == T_LAST) state_nxt = S_DONE;
            S_READ:  if (issue && n_wrap && t_cnt == '0)      state_nxt = S_DRAIN;
            S_DRAIN: if (count == 2'd0 && !in_flight)         state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt <= '0;
            t_cnt <= '0;
            base  <= '0;
        end else if (state == S_IDLE) begin
            if (start_wr) begin
                n_cnt <= '0;
                t_cnt <= '0;
                base  <= '0;
            end else if (start_rd) begin
                n_cnt <= '0;
                t_cnt <= T_LAST;
                base  <= LAST_BASE;
            end
        end else if (accept || issue) begin
            if (n_wrap) begin
                n_cnt <= '0;
                if (state == S_WRITE) begin
                    t_cnt <= t_cnt + TW'(1);
                    base  <= base + STEP;
                end else begin
                    t_cnt <= t_cnt - TW'(1);
                    base  <= base - STEP;
                end
            end else begin
                n_cnt <= n_cnt + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight   <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            in_flight <= issue;
            if (in_flight) begin
                fifo_mem[wr_ptr] <= mem_dout_b;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({in_flight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_state_streamer.sv
// Self-checking bench: a 4x3 instance for sequencing/corner cases and a 53x1
// instance for the single-timestep case, each with its own dual-port memory model.
module tb_cell_state_streamer;
    localparam int NA = 4, TA = 3, NB = 53, TB = 1, W = 32, AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          start_wr, start_rd, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data, mem_din, mem_dout_b;
    logic          mem_wr, busy, done;
    logic [AW-1:0] mem_addr_a, mem_addr_b;

    logic          b_start_wr, b_start_rd, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0]  b_in_data, b_out_data, b_mem_din, b_mem_dout_b;
    logic          b_mem_wr, b_busy, b_done;
    logic [AW-1:0] b_mem_addr_a, b_mem_addr_b;

    cell_state_streamer #(.ADDR(AW), .WIDTH(W), .NUM(NA), .TIMESTEP(TA)) dut (
        .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_wr(mem_wr), .mem_addr_a(mem_addr_a), .mem_din(mem_din),
        .mem_addr_b(mem_addr_b), .mem_dout_b(mem_dout_b), .busy(busy), .done(done));

    cell_state_streamer #(.ADDR(AW), .WIDTH(W), .NUM(NB), .TIMESTEP(TB)) dut53 (
        .clk(clk), .rst_n(rst_n), .start_wr(b_start_wr), .start_rd(b_start_rd),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .mem_wr(b_mem_wr), .mem_addr_a(b_mem_addr_a), .mem_din(b_mem_din),
        .mem_addr_b(b_mem_addr_b), .mem_dout_b(b_mem_dout_b), .busy(b_busy), .done(b_done));

    logic [W-1:0] mem_a [0:4095];
    logic [W-1:0] mem_b [0:4095];
    always @(posedge clk) begin
        if (mem_wr) mem_a[mem_addr_a] <= mem_din;
        mem_dout_b <= mem_a[mem_addr_b];
        if (b_mem_wr) mem_b[b_mem_addr_a] <= b_mem_din;
        b_mem_dout_b <= mem_b[b_mem_addr_b];
    end

    int total = 0;
    int bad = 0;
    logic [W-1:0] refm [0:NA*TA-1];

    typedef struct {
        bit          valid;
        logic [31:0] data;
        bit          exp_wr;
        int          exp_addr;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // i-th value on the output stream: timesteps last-to-first, cells in order.
    function automatic int rd_addr(input int i);
        return (TA - 1 - i / NA) * NA + i % NA;
    endfunction

    // Position of a memory address in that reverse output order.
    function automatic int pos_of(input int a);
        return (TA - 1 - a / NA) * NA + a % NA;
    endfunction

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_mem_wr"}, mem_wr, 0);
        chk({nm, "_addr_a"}, mem_addr_a, 0);
        chk({nm, "_din"}, mem_din, 0);
        chk({nm, "_addr_b"}, mem_addr_b, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    task automatic write_tbl();
        step(); start_wr = 1'b1;
        step(); start_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = tbl[i].valid;
            in_data  = tbl[i].data;
            settle();
            chk("tbl_in_ready", in_ready, 1);
            chk("tbl_mem_wr", mem_wr, tbl[i].exp_wr);
            if (tbl[i].exp_wr) begin
                chk("tbl_addr_a", mem_addr_a, tbl[i].exp_addr);
                chk("tbl_din", mem_din, tbl[i].data);
                refm[tbl[i].exp_addr] = tbl[i].data;
            end
            step();
        end
        in_valid = 1'b0;
        settle();
        chk("tbl_done", done, 1);
        chk("tbl_done_busy", busy, 1);
        step(); settle();
        chk("tbl_done_once", done, 0);
        chk("tbl_idle", busy, 0);
    endtask

    task automatic write_run(input int gap_pct, input bit both, input bit mid_rd);
        int k = 0;
        int cyc = 0;
        bit iv;
        logic [W-1:0] d;
        step(); start_wr = 1'b1; start_rd = both;
        step(); start_wr = 1'b0; start_rd = 1'b0;
        while (k < NA * TA && cyc < 200) begin
            iv = ($urandom_range(99) >= gap_pct);
            d  = $urandom;
            in_valid = iv;
            in_data  = d;
            start_rd = mid_rd && (k == 5);
            settle();
            chk("wr_in_ready", in_ready, 1);
            chk("wr_mem_wr", mem_wr, iv);
            if (iv) begin
                chk("wr_addr_a", mem_addr_a, k);
                chk("wr_din", mem_din, d);
                refm[k] = d;
                k++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        start_rd = 1'b0;
        if (k < NA * TA) chk("wr_timeout", k, NA * TA);
        settle();
        chk("wr_done", done, 1);
        step(); settle();
        chk("wr_done_once", done, 0);
        chk("wr_idle", busy, 0);
    endtask

    task automatic read_run(input bit rand_rdy, input int abort_at);
        int p = 0;
        int cyc = 1;
        int first = -1;
        int last = -1;
        int dn = 0;
        step(); start_rd = 1'b1;
        step(); start_rd = 1'b0;
        while (cyc < 400) begin
            out_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
            settle();
            if (dn > 0 && !done) begin
                chk("rd_idle_after_done", busy, 0);
                break;
            end
            if (out_valid && out_ready) begin
                if (p < NA * TA) chk("rd_data", out_data, refm[rd_addr(p)]);
                if (first < 0) first = cyc;
                last = cyc;
                p++;
            end
            if (mem_addr_b != '0)
                chk("rd_ahead", 32'(pos_of(int'(mem_addr_b)) <= p + 1), 1);
            if (done) begin
                dn++;
                chk("rd_done_after_all", p, NA * TA);
                chk("rd_done_busy", busy, 1);
            end
            if (abort_at > 0 && p == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                step(); step();
                rst_n = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    settle();
                    chk("abort_no_done", done, 0);
                    chk("abort_stays_idle", busy, 0);
                    step();
                end
                return;
            end
            step();
            cyc++;
        end
        chk("rd_done_count", dn, 1);
        chk("rd_beats", p, NA * TA);
        if (!rand_rdy) begin
            chk("rd_first_valid", first, 3);
            chk("rd_back_to_back", last, 3 + NA * TA - 1);
        end
    endtask

    initial begin
        int p, bdn;
        rst_n = 1'b0;
        {start_wr, start_rd, in_valid, out_ready} = '0;
        in_data = '0;
        {b_start_wr, b_start_rd, b_in_valid, b_out_ready} = '0;
        b_in_data = '0;
        for (int i = 0; i < 12; i++) tbl[i] = '{valid: 1'b1, data: i, exp_wr: 1'b1, exp_addr: i};

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        write_tbl();
        read_run(1'b0, 0);
        read_run(1'b1, 0);
        read_run(1'b1, 0);

        write_run(30, 1'b0, 1'b0);
        read_run(1'b1, 0);

        write_run(20, 1'b1, 1'b1);
        read_run(1'b1, 0);

        read_run(1'b0, 5);
        read_run(1'b0, 0);

        step(); b_start_wr = 1'b1;
        step(); b_start_wr = 1'b0;
        for (int k = 0; k < NB; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = k;
            settle();
            chk("b_wr_addr", b_mem_addr_a, k);
            chk("b_wr_en", b_mem_wr, 1);
            step();
        end
        b_in_valid = 1'b0;
        settle();
        chk("b_wr_done", b_done, 1);
        step(); b_start_rd = 1'b1;
        step(); b_start_rd = 1'b0;
        b_out_ready = 1'b1;
        p = 0;
        bdn = 0;
        for (int c = 1; c <= 60; c++) begin
            settle();
            if (c <= NB) chk("b_rd_addr", b_mem_addr_b, c - 1);
            if (b_out_valid) begin
                chk("b_rd_data", b_out_data, p);
                p++;
            end
            if (b_done) bdn++;
            step();
        end
        chk("b_rd_beats", p, NB);
        chk("b_rd_done_count", bdn, 1);
        chk("b_idle", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
